npu_param_loader: RTL and testbench
===================================

# npu_param_loader

Streaming parameter loader for the NPU datapath. Accepts a valid/ready stream of DATA_WIDTH-bit words and deserialises it into the flat `weights_flat` / `biases_flat` buses consumed by the NPU top level. It holds them as registers and raises `params_valid` once a complete, correctly framed parameter set has been received. It sits between the host/DMA word stream and the NPU parameter ports.

## Interface
- `NUM_LAYERS`, default `NUM_LAYERS` macro: layer count; must be ≥ 2.
- `LAYER_SIZES[0:NUM_LAYERS-1]`, default `LAYER_SIZES` macro: neurons per layer.
- `DATA_WIDTH`, default `DATA_WIDTH` macro: bits per word.
- Derived local constants:
  - `W_BITS` = sum over i=1..NUM_LAYERS-1 of LAYER_SIZES[i]·LAYER_SIZES[i-1]·DATA_WIDTH.
  - `B_BITS` = sum over i=1..NUM_LAYERS-1 of LAYER_SIZES[i]·DATA_WIDTH.
  - `W_WORDS` = W_BITS/DATA_WIDTH, `B_WORDS` = B_BITS/DATA_WIDTH, `N` = W_WORDS+B_WORDS.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active low.
- `start` in 1: single-cycle pulse that begins a new load.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader accepts a word.
- `s_data` in DATA_WIDTH: stream word.
- `s_last` in 1: marks the final word of the set.
- `weights_flat` out W_BITS: signed packed weights.
- `biases_flat` out B_BITS: signed packed biases.
- `params_valid` out 1: complete set loaded.
- `error` out 1: sticky framing error.

## Operation
- FSM states: IDLE, LOAD_W, LOAD_B, DONE.
- `s_ready` = (state == LOAD_W || state == LOAD_B), decoded from registered state only. A beat is a cycle with `s_valid && s_ready`.
- `start` is honoured in any state and has priority over all other events:
  - next state LOAD_W, word counter ← 0, `params_valid` ← 0, `error` ← 0.
  - a beat coinciding with `start` is consumed and discarded.
  - `weights_flat` / `biases_flat` are not cleared.
- LOAD_W: beat k writes `weights_flat[k*DATA_WIDTH +: DATA_WIDTH]`. This is the same ascending order as the per-layer slicing: layer 1 first, at offset 0. After word W_WORDS-1 the counter resets to 0 and the state goes to LOAD_B.
- LOAD_B: beat k writes `biases_flat[k*DATA_WIDTH +: DATA_WIDTH]`. On word B_WORDS-1 with `s_last`=1, the state goes to DONE and `params_valid` ← 1.
- Framing check: `s_last` on any beat other than the final bias word, or `s_last`=0 on the final bias word, causes:
  - `error` ← 1, state ← IDLE, `params_valid` stays 0.
  - the offending word is still written.
- DONE and IDLE hold their outputs until `start`. Beats are impossible in these states because `s_ready` is 0.
- Word counter width: $clog2(max(W_WORDS, B_WORDS)). There is no wrap other than the LOAD_W→LOAD_B transition.

## Timing
- Reset (async assert, sync deassert at the consumer): state IDLE, counter 0, `s_ready` 0, `params_valid` 0, `error` 0, `weights_flat` 0, `biases_flat` 0.
- `start` sampled at edge 0 puts the block in LOAD_W from cycle 1. With `s_valid` held high, beats occur in cycles 1..N and `params_valid` is 1 from cycle N+1.
- Each accepted word is visible on the flat bus in the cycle after its beat.
- Throughput: one word per cycle. There is no bubble between LOAD_W and LOAD_B.
- `rst_n` asserted mid-load aborts immediately. Everything returns to reset values and a new `start` is required.
- Consumers use the flat buses only while `params_valid`=1. The buses are stable throughout DONE.

## Structure
- Shared package `npu_pkg` holds:
  - `calc_weights_bits` and `calc_biases_bits` as the single source for W_BITS/B_BITS, also used by the NPU top level.
  - the loader state enum typedef `loader_state_t`.
- There is no sub-module. FSM, counter and indexed register writes live in one module.

## Test plan
All scenarios use NUM_LAYERS=3, LAYER_SIZES={2,3,1}, DATA_WIDTH=8, giving W_WORDS=9, B_WORDS=4, N=13.
- Reset: assert `rst_n`=0 mid-simulation → all outputs 0 and `s_ready`=0 asynchronously.
- Full load: `start`, then words 0x01..0x0D back-to-back with `s_last` on 0x0D → `weights_flat`=0x090807060504030201, `biases_flat`=0x0D0C0B0A, `params_valid`=1 at cycle 14, `s_ready`=0 thereafter.
- Bubbles: the same words with `s_valid` toggled pseudo-randomly → identical final buses; `params_valid` rises exactly one cycle after the 13th beat.
- Early `s_last` on word 5 → `error`=1, `s_ready`=0, `params_valid`=0. A following `start` clears `error`.
- Missing `s_last` on word 13 → `error`=1, `params_valid`=0. Biases show 0x0D in the top byte.
- `start` reissued at word 7 of a load, then a full 13-word load of 0x11..0x1D → final `weights_flat`=0x191817161514131211, `params_valid`=1. Separately, `rst_n` pulsed low at word 7 → all outputs zero and no progress without `start`.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default network shape, parameter-bus sizing helpers
// and the parameter-loader state encoding.
`default_nettype none

`ifndef NUM_LAYERS
`define NUM_LAYERS 3
`endif
`ifndef LAYER_SIZES
`define LAYER_SIZES {32'd2, 32'd3, 32'd1}
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package npu_pkg;

  localparam int MAX_LAYERS = 16;

  // Layer sizes travel as a packed [0:n-1][31:0] vector zero-extended on the left,
  // so element i sits at word (n-1-i) counting from the LSB.
  typedef logic [MAX_LAYERS*32-1:0] sizes_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } loader_state_t;

  function automatic int layer_size(input int n, input sizes_vec_t s, input int i);
    return int'(s[(n-1-i)*32 +: 32]);
  endfunction

  function automatic int calc_weights_bits(input int n, input sizes_vec_t s, input int dw);
    int acc;
    acc = 0;
    for (int i = 1; i < MAX_LAYERS; i++)
      if (i < n) acc += layer_size(n, s, i) * layer_size(n, s, i-1) * dw;
    return acc;
  endfunction

  function automatic int calc_biases_bits(input int n, input sizes_vec_t s, input int dw);
    int acc;
    acc = 0;
    for (int i = 1; i < MAX_LAYERS; i++)
      if (i < n) acc += layer_size(n, s, i) * dw;
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/npu_param_loader.sv
// Deserialises a valid/ready word stream into registered flat weight/bias buses,
// checking that s_last frames exactly the final bias word.
`default_nettype none

module npu_param_loader
  import npu_pkg::*;
#(
  parameter int                             NUM_LAYERS  = `NUM_LAYERS,
  parameter logic [0:NUM_LAYERS-1][31:0]    LAYER_SIZES = `LAYER_SIZES,
  parameter int                             DATA_WIDTH  = `DATA_WIDTH,
  localparam int W_BITS = calc_weights_bits(NUM_LAYERS, sizes_vec_t'(LAYER_SIZES), DATA_WIDTH),
  localparam int B_BITS = calc_biases_bits(NUM_LAYERS, sizes_vec_t'(LAYER_SIZES), DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [W_BITS-1:0]     weights_flat,
  output logic [B_BITS-1:0]     biases_flat,
  output logic                  params_valid,
  output logic                  error
);

  localparam int W_WORDS = W_BITS / DATA_WIDTH;
  localparam int B_WORDS = B_BITS / DATA_WIDTH;
  localparam int MAX_WORDS = (W_WORDS > B_WORDS) ? W_WORDS : B_WORDS;
  localparam int CW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  loader_state_t      r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_pv, r_err;
  logic [W_BITS-1:0]  r_weights;
  logic [B_BITS-1:0]  r_biases;
  logic               w_ready, w_beat, w_last_w, w_last_b;
  logic               w_set_pv, w_set_err, w_wr_w, w_wr_b;

  assign w_ready  = (r_state == LOAD_W) || (r_state == LOAD_B);
  assign w_beat   = s_valid && w_ready;
  assign w_last_w = (r_cnt == CW'(W_WORDS-1));
  assign w_last_b = (r_cnt == CW'(B_WORDS-1));
  // A beat coinciding with start is swallowed, never stored.
  assign w_wr_w   = w_beat && !start && (r_state == LOAD_W);
  assign w_wr_b   = w_beat && !start && (r_state == LOAD_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_set_pv    = 1'b0;
    w_set_err   = 1'b0;
    if (start) begin
      w_state_nxt = LOAD_W;
      w_cnt_nxt   = '0;
    end else if (w_beat) begin
      unique case (r_state)
        LOAD_W: begin
          if (s_last) begin
            w_state_nxt = IDLE;
            w_set_err   = 1'b1;
            w_cnt_nxt   = '0;
          end else if (w_last_w) begin
            w_state_nxt = LOAD_B;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        LOAD_B: begin
          if (w_last_b && s_last) begin
            w_state_nxt = DONE;
            w_set_pv    = 1'b1;
            w_cnt_nxt   = '0;
          end else if (w_last_b || s_last) begin
            w_state_nxt = IDLE;
            w_set_err   = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pv      <= 1'b0;
      r_err     <= 1'b0;
      r_weights <= '0;
      r_biases  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (start) begin
        r_pv  <= 1'b0;
        r_err <= 1'b0;
      end else begin
        if (w_set_pv)  r_pv  <= 1'b1;
        if (w_set_err) r_err <= 1'b1;
      end
      for (int k = 0; k < W_WORDS; k++)
        if (w_wr_w && (r_cnt == CW'(k))) r_weights[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
      for (int k = 0; k < B_WORDS; k++)
        if (w_wr_b && (r_cnt == CW'(k))) r_biases[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
    end
  end

  assign s_ready      = w_ready;
  assign weights_flat = r_weights;
  assign biases_flat  = r_biases;
  assign params_valid = r_pv;
  assign error        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_npu_param_loader.sv
// Scoreboard bench for npu_param_loader with the 2-3-1 / 8-bit default network.
`default_nettype none

module tb_npu_param_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic [71:0] weights_flat;
  logic [31:0] biases_flat;
  logic        params_valid;
  logic        error;

  npu_param_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .weights_flat (weights_flat),
    .biases_flat  (biases_flat),
    .params_valid (params_valid),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [71:0] w;
    logic [71:0] wm;
    logic [31:0] b;
    logic [31:0] bm;
    logic        pv;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_beat_edge = -1;
  int   comp_cyc = -1;
  int   start_edge = 0;
  logic prev_evt = 1'b0;

  localparam logic [71:0] W_FULL  = {72{1'b1}};
  localparam logic [31:0] B_FULL  = 32'hFFFF_FFFF;
  localparam logic [15:0] BUBBLES = 16'b1011_0010_1101_0110;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every rising completion/error event consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    logic evt;
    evt = params_valid || error;
    if (evt && !prev_evt) begin
      comp_cyc = cyc;
      if (expq.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = expq.pop_front();
        check({e.name, "_weights"}, weights_flat & e.wm, e.w & e.wm);
        check({e.name, "_biases"}, biases_flat & e.bm, e.b & e.bm);
        check({e.name, "_params_valid"}, params_valid, e.pv);
        check({e.name, "_error"}, error, e.err);
        // Status visible in the cycle right after the final beat's edge.
        check({e.name, "_latency"}, cyc, last_beat_edge);
      end
    end
    if (s_valid && s_ready && !start && rst_n) last_beat_edge = cyc + 1;
    prev_evt = evt;
  end

  task automatic push(input string nm, input logic [71:0] w, input logic [71:0] wm,
                      input logic [31:0] b, input logic [31:0] bm, input logic pv, input logic err);
    exp_t e;
    e.name = nm; e.w = w; e.wm = wm; e.b = b; e.bm = bm; e.pv = pv; e.err = err;
    expq.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    start_edge = cyc;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic bub);
    logic rdy;
    int   n;
    if (bub) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clk) rdy = s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!rdy) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_s_ready", s_ready, 0);
    check("reset_params_valid", params_valid, 0);
    check("reset_error", error, 0);
    check("reset_weights", weights_flat, 0);
    check("reset_biases", biases_flat, 0);
    @(posedge clk); #1;

    // Full back-to-back load.
    push("full", 72'h09_0807_0605_0403_0201, W_FULL, 32'h0D0C_0B0A, B_FULL, 1, 0);
    pulse_start();
    for (int i = 1; i <= 13; i++) send(8'(i), i == 13, 1'b0);
    idle(3);
    check("full_pv_cycle", comp_cyc - start_edge, 13);
    @(negedge clk);
    check("full_s_ready_after", s_ready, 0);
    check("full_pv_held", params_valid, 1);
    @(posedge clk); #1;

    // Same words with bubbles.
    push("bubbles", 72'h09_0807_0605_0403_0201, W_FULL, 32'h0D0C_0B0A, B_FULL, 1, 0);
    pulse_start();
    for (int i = 1; i <= 13; i++) send(8'(i), i == 13, BUBBLES[i]);
    idle(3);

    // Early s_last on word 5.
    push("early_last", '0, '0, '0, '0, 0, 1);
    pulse_start();
    for (int i = 1; i <= 5; i++) send(8'(i), i == 5, 1'b0);
    idle(2);
    @(negedge clk);
    check("early_s_ready", s_ready, 0);
    check("early_pv", params_valid, 0);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    check("start_clears_error", error, 0);
    check("start_sets_ready", s_ready, 1);
    @(posedge clk); #1;

    // Missing s_last on the final bias word.
    push("missing_last", 72'h09_0807_0605_0403_0201, W_FULL, 32'h0D00_0000, 32'hFF00_0000, 0, 1);
    pulse_start();
    for (int i = 1; i <= 13; i++) send(8'(i), 1'b0, 1'b0);
    idle(3);

    // Restart at word 7; the beat alongside start is dropped.
    push("restart", 72'h19_1817_1615_1413_1211, W_FULL, 32'h1D1C_1B1A, B_FULL, 1, 0);
    pulse_start();
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0, 1'b0);
    start = 1'b1; s_valid = 1'b1; s_data = 8'h07; s_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 13; i++) send(8'(8'h11 + i), i == 12, 1'b0);
    idle(3);

    // Asynchronous reset at word 7.
    pulse_start();
    for (int i = 1; i <= 6; i++) send(8'(8'h20 + i), 1'b0, 1'b0);
    s_valid = 1'b1; s_data = 8'h27;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_s_ready", s_ready, 0);
    check("async_rst_weights", weights_flat, 0);
    check("async_rst_biases", biases_flat, 0);
    check("async_rst_pv", params_valid, 0);
    check("async_rst_error", error, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("no_progress_s_ready", s_ready, 0);
    check("no_progress_weights", weights_flat, 0);
    check("no_progress_pv", params_valid, 0);
    idle(1);

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
